// File: rtl/red_pkg.sv
// Shared types for the red_pipe datapath: ALU operation encodings and register-file sizing.
package red_pkg;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_XOR  = 3'b100,
      ALU_SLT  = 3'b101,
      ALU_SLL  = 3'b110,
      ALU_PASS = 3'b111
   } alu_op_t;

   localparam int DEF_ADDRESS_WIDTH = 5;
   localparam int REG_COUNT         = 2**DEF_ADDRESS_WIDTH;

   function automatic int reg_count(input int address_width);
      return 2**address_width;
   endfunction

endpackage

// File: rtl/alu_n.sv
// Combinational ALU with operand-equality flag; zero latency, no flow control.
module alu_n
   import red_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] op1_i,
   input  logic [DATA_WIDTH-1:0] op2_i,
   input  alu_op_t               ctr_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  eq_o
);

   localparam int SHW = $clog2(DATA_WIDTH);

   logic slt_bit;

   assign slt_bit = ($signed(op1_i) < $signed(op2_i));
   assign eq_o    = (op1_i == op2_i);

   always_comb begin
      result_o = '0;
      case (ctr_i)
         ALU_ADD:  result_o = op1_i + op2_i;
         ALU_SUB:  result_o = op1_i - op2_i;
         ALU_AND:  result_o = op1_i & op2_i;
         ALU_OR:   result_o = op1_i | op2_i;
         ALU_XOR:  result_o = op1_i ^ op2_i;
         ALU_SLT:  result_o = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
         // Only the low log2(DATA_WIDTH) bits of op2 form the shift amount.
         ALU_SLL:  result_o = op1_i << op2_i[SHW-1:0];
         ALU_PASS: result_o = op2_i;
         default:  result_o = '0;
      endcase
   end

endmodule

// File: rtl/red_pipe.sv
// Two-stage EX/WB datapath: register file, WB->EX forwarding, ALU; result architectural 2 edges after issue.
// No backpressure: every in_valid cycle is accepted, dependent back-to-back ops never stall.
module red_pipe
   import red_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int A0_INDEX      = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [ADDRESS_WIDTH-1:0] ad1,
   input  logic [ADDRESS_WIDTH-1:0] ad2,
   input  logic [ADDRESS_WIDTH-1:0] ad3,
   input  logic                     we3,
   input  logic                     aluSrc,
   input  logic [2:0]               aluCTR,
   input  logic [DATA_WIDTH-1:0]    immOp,
   output logic                     eq,
   output logic                     eq_valid,
   output logic [DATA_WIDTH-1:0]    a0
);

   localparam int                       NREG   = reg_count(ADDRESS_WIDTH);
   localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(A0_INDEX);

   logic [DATA_WIDTH-1:0]    rf_q [NREG];
   logic                     wb_vld_q, wb_vld_d;
   logic [DATA_WIDTH-1:0]    wb_dat_q, wb_dat_d;
   logic [ADDRESS_WIDTH-1:0] wb_idx_q, wb_idx_d;
   logic                     wb_we_q,  wb_we_d;
   logic                     eq_q, eq_d;
   logic                     eq_valid_q, eq_valid_d;
   logic [DATA_WIDTH-1:0]    a0_q;

   logic                     wb_hit;
   logic [DATA_WIDTH-1:0]    op1, rd2, op2, alu_res;
   logic                     alu_eq;

   // A WB op that commits this edge; index 0 never commits and never forwards.
   assign wb_hit = wb_vld_q && wb_we_q && (wb_idx_q != '0);

   assign op1 = (ad1 == '0) ? '0 : (wb_hit && wb_idx_q == ad1) ? wb_dat_q : rf_q[ad1];
   assign rd2 = (ad2 == '0) ? '0 : (wb_hit && wb_idx_q == ad2) ? wb_dat_q : rf_q[ad2];
   assign op2 = aluSrc ? immOp : rd2;

   alu_n #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .op1_i    (op1),
      .op2_i    (op2),
      .ctr_i    (alu_op_t'(aluCTR)),
      .result_o (alu_res),
      .eq_o     (alu_eq)
   );

   always_comb begin
      wb_vld_d   = 1'b0;
      wb_dat_d   = wb_dat_q;
      wb_idx_d   = wb_idx_q;
      wb_we_d    = wb_we_q;
      eq_d       = eq_q;
      eq_valid_d = 1'b0;
      if (in_valid) begin
         wb_vld_d   = 1'b1;
         wb_dat_d   = alu_res;
         wb_idx_d   = ad3;
         wb_we_d    = we3;
         eq_d       = alu_eq;
         eq_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
         wb_vld_q   <= 1'b0;
         wb_dat_q   <= '0;
         wb_idx_q   <= '0;
         wb_we_q    <= 1'b0;
         eq_q       <= 1'b0;
         eq_valid_q <= 1'b0;
         a0_q       <= '0;
      end else begin
         if (wb_hit) begin
            rf_q[wb_idx_q] <= wb_dat_q;
            if (wb_idx_q == A0_IDX) begin
               a0_q <= wb_dat_q;
            end
         end
         wb_vld_q   <= wb_vld_d;
         wb_dat_q   <= wb_dat_d;
         wb_idx_q   <= wb_idx_d;
         wb_we_q    <= wb_we_d;
         eq_q       <= eq_d;
         eq_valid_q <= eq_valid_d;
      end
   end

   assign eq       = eq_q;
   assign eq_valid = eq_valid_q;
   assign a0       = a0_q;

endmodule

// File: tb/tb_red_pipe.sv
// Directed bench for red_pipe: default 32-bit instance plus a 16-bit / 8-register instance.
module tb_red_pipe;
   import red_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, we3, aluSrc;
   logic [4:0]  ad1, ad2, ad3;
   logic [2:0]  aluCTR;
   logic [31:0] immOp;
   logic        eq, eq_valid;
   logic [31:0] a0;

   logic        s_in_valid, s_we3, s_aluSrc;
   logic [2:0]  s_ad1, s_ad2, s_ad3;
   logic [2:0]  s_aluCTR;
   logic [15:0] s_immOp;
   logic        s_eq, s_eq_valid;
   logic [15:0] s_a0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   red_pipe #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .A0_INDEX(10)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .ad1(ad1), .ad2(ad2), .ad3(ad3), .we3(we3),
      .aluSrc(aluSrc), .aluCTR(aluCTR), .immOp(immOp),
      .eq(eq), .eq_valid(eq_valid), .a0(a0)
   );

   red_pipe #(.ADDRESS_WIDTH(3), .DATA_WIDTH(16), .A0_INDEX(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid),
      .ad1(s_ad1), .ad2(s_ad2), .ad3(s_ad3), .we3(s_we3),
      .aluSrc(s_aluSrc), .aluCTR(s_aluCTR), .immOp(s_immOp),
      .eq(s_eq), .eq_valid(s_eq_valid), .a0(s_a0)
   );

   typedef struct {
      logic        src;
      alu_op_t     ctr;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] imm;
      logic [31:0] exp_res;
      logic        exp_eq;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] a3, input logic we, input logic src,
                        input logic [2:0] c, input logic [31:0] im);
      in_valid = v; ad1 = a1; ad2 = a2; ad3 = a3;
      we3 = we; aluSrc = src; aluCTR = c; immOp = im;
   endtask

   task automatic bubble();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ALU_ADD, 32'd0);
   endtask

   task automatic sdrive(input logic v, input logic [2:0] a1, input logic [2:0] a3,
                         input logic [2:0] c, input logic [15:0] im);
      s_in_valid = v; s_ad1 = a1; s_ad2 = 3'd0; s_ad3 = a3;
      s_we3 = 1'b1; s_aluSrc = 1'b1; s_aluCTR = c; s_immOp = im;
   endtask

   // Load a register via x0 + imm and let it reach the register file.
   task automatic wr(input logic [4:0] idx, input logic [31:0] val);
      drive(1'b1, 5'd0, 5'd0, idx, 1'b1, 1'b1, ALU_ADD, val);
      tick();
      bubble();
      tick();
   endtask

   initial begin
      tbl[0]  = '{1'b0, ALU_ADD,  5'd3, 5'd4, 32'h0,        32'd8,        1'b0};
      tbl[1]  = '{1'b1, ALU_ADD,  5'd1, 5'd0, 32'h1,        32'h0,        1'b0};
      tbl[2]  = '{1'b0, ALU_SLT,  5'd1, 5'd2, 32'h0,        32'h1,        1'b0};
      tbl[3]  = '{1'b0, ALU_SUB,  5'd3, 5'd4, 32'h0,        32'hFFFFFFFE, 1'b0};
      tbl[4]  = '{1'b1, ALU_AND,  5'd1, 5'd0, 32'hF0,       32'hF0,       1'b0};
      tbl[5]  = '{1'b0, ALU_OR,   5'd3, 5'd4, 32'h0,        32'h7,        1'b0};
      tbl[6]  = '{1'b0, ALU_XOR,  5'd7, 5'd8, 32'h0,        32'h0,        1'b1};
      tbl[7]  = '{1'b1, ALU_SLL,  5'd3, 5'd0, 32'd33,       32'h6,        1'b0};
      tbl[8]  = '{1'b1, ALU_PASS, 5'd3, 5'd0, 32'h1234,     32'h1234,     1'b0};
      tbl[9]  = '{1'b0, ALU_SLT,  5'd2, 5'd1, 32'h0,        32'h0,        1'b0};
      tbl[10] = '{1'b1, ALU_SLL,  5'd2, 5'd0, 32'd31,       32'h80000000, 1'b0};
      tbl[11] = '{1'b1, ALU_AND,  5'd1, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};

      sdrive(1'b0, 3'd0, 3'd0, ALU_ADD, 16'd0);

      // Reset held for two edges while ops are being issued.
      rst_n = 1'b0;
      drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, ALU_ADD, 32'd99);
      tick();
      tick();
      chk("rst_a0", a0, 32'd0);
      chk("rst_eq", {31'd0, eq}, 32'd0);
      chk("rst_eq_valid", {31'd0, eq_valid}, 32'd0);
      chk("rst_s_a0", {16'd0, s_a0}, 32'd0);
      bubble();
      rst_n = 1'b1;
      tick();
      chk("rst_release_a0", a0, 32'd0);

      wr(5'd3, 32'h77);
      wr(5'd10, 32'h42);
      chk("pre_reset_a0", a0, 32'h42);

      // Op issued one edge before reset must be discarded.
      drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, ALU_ADD, 32'h55);
      tick();
      rst_n = 1'b0;
      bubble();
      tick();
      tick();
      rst_n = 1'b1;
      chk("late_rst_a0", a0, 32'd0);
      tick();
      chk("late_rst_a0_after", a0, 32'd0);

      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 5'(i), 5'd0, 5'd0, 1'b0, 1'b0, ALU_ADD, 32'd0);
         tick();
         chk($sformatf("reg%0d_zero", i), {31'd0, eq}, 32'd1);
      end
      bubble();
      tick();

      // Back-to-back dependent immediate adds.
      drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, ALU_ADD, 32'd5);
      tick();
      drive(1'b1, 5'd10, 5'd0, 5'd10, 1'b1, 1'b1, ALU_ADD, 32'd3);
      tick();
      chk("fwd_a0_first", a0, 32'd5);
      bubble();
      tick();
      chk("fwd_a0_second", a0, 32'd8);

      // rd2 forwarding, then a third op sees the later of two writes.
      drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, ALU_ADD, 32'h20);
      tick();
      drive(1'b1, 5'd0, 5'd10, 5'd10, 1'b1, 1'b0, ALU_SUB, 32'd0);
      tick();
      chk("fwd2_a0_a", a0, 32'h20);
      drive(1'b1, 5'd10, 5'd0, 5'd10, 1'b1, 1'b1, ALU_XOR, 32'hFFFFFFE0);
      tick();
      chk("fwd2_a0_b", a0, 32'hFFFFFFE0);
      chk("fwd2_eq", {31'd0, eq}, 32'd1);
      chk("fwd2_eq_valid", {31'd0, eq_valid}, 32'd1);
      bubble();
      tick();
      chk("fwd2_a0_c", a0, 32'd0);
      chk("fwd2_eq_valid_drop", {31'd0, eq_valid}, 32'd0);

      // x0 protection: a write to index 0 is neither stored nor forwarded.
      wr(5'd10, 32'h11);
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, ALU_ADD, 32'hDEAD);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, ALU_PASS, 32'hBEEF);
      tick();
      chk("x0_a0_unchanged", a0, 32'h11);
      bubble();
      tick();
      chk("x0_read_zero", a0, 32'd0);

      wr(5'd1, 32'hFFFFFFFF);
      wr(5'd2, 32'd1);
      wr(5'd3, 32'd3);
      wr(5'd4, 32'd5);
      wr(5'd7, 32'd7);
      wr(5'd8, 32'd7);

      for (int i = 0; i < 12; i++) begin
         drive(1'b1, tbl[i].a1, tbl[i].a2, 5'd10, 1'b1, tbl[i].src, tbl[i].ctr, tbl[i].imm);
         tick();
         chk($sformatf("vec%0d_eq", i), {31'd0, eq}, {31'd0, tbl[i].exp_eq});
         chk($sformatf("vec%0d_eq_valid", i), {31'd0, eq_valid}, 32'd1);
         bubble();
         tick();
         chk($sformatf("vec%0d_res", i), a0, tbl[i].exp_res);
         chk($sformatf("vec%0d_eq_valid_drop", i), {31'd0, eq_valid}, 32'd0);
      end

      // eq then bubble: eq holds, eq_valid drops, bubble writes nothing.
      drive(1'b1, 5'd7, 5'd8, 5'd10, 1'b1, 1'b0, ALU_ADD, 32'd0);
      tick();
      chk("eqb_eq", {31'd0, eq}, 32'd1);
      chk("eqb_eq_valid", {31'd0, eq_valid}, 32'd1);
      drive(1'b0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, ALU_PASS, 32'h99);
      tick();
      chk("eqb_hold_eq", {31'd0, eq}, 32'd1);
      chk("eqb_hold_eq_valid", {31'd0, eq_valid}, 32'd0);
      chk("eqb_a0", a0, 32'd14);
      tick();
      chk("eqb_no_write", a0, 32'd14);
      chk("eqb_hold_eq2", {31'd0, eq}, 32'd1);
      bubble();

      // Narrow instance: 0xFFFF + 2 wraps to 1, sll by 17 shifts by 1.
      sdrive(1'b1, 3'd0, 3'd1, ALU_ADD, 16'hFFFF);
      tick();
      sdrive(1'b1, 3'd1, 3'd2, ALU_ADD, 16'd2);
      tick();
      chk("sweep_a0_idle", {16'd0, s_a0}, 32'd0);
      sdrive(1'b1, 3'd2, 3'd2, ALU_SLL, 16'd17);
      tick();
      chk("sweep_wrap", {16'd0, s_a0}, 32'h0001);
      sdrive(1'b0, 3'd0, 3'd0, ALU_ADD, 16'd0);
      tick();
      chk("sweep_sll", {16'd0, s_a0}, 32'h0002);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
